// File: rtl/note_player_pkg.sv
// Shared types and default sizing for the note player and its tempo prescaler.
// Also used by the upstream sequencer so both sides agree on widths.
package note_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int HALF_W_DEFAULT = 16;
  localparam int DUR_W_DEFAULT  = 12;
  localparam int TPM_W_DEFAULT  = 16;
  localparam int GAP_MS_DEFAULT = 10;

endpackage

// File: rtl/note_if.sv
// Note command handshake between the sequencer (master) and the note player (slave).
interface note_if import note_player_pkg::*; #(
  parameter int HALF_W = HALF_W_DEFAULT,
  parameter int DUR_W  = DUR_W_DEFAULT
);

  logic              note_valid;
  logic              note_ready;
  logic [HALF_W-1:0] note_half_period;
  logic [DUR_W-1:0]  note_dur_ms;

  modport master (
    output note_valid,
    output note_half_period,
    output note_dur_ms,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_half_period,
    input  note_dur_ms,
    output note_ready
  );

endinterface

// File: rtl/ms_timer.sv
// Millisecond prescaler: counts 0..tpm-1 while enabled and strobes on the wrap cycle.
module ms_timer import note_player_pkg::*; #(
  parameter int TPM_W = TPM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TPM_W-1:0] tpm,
  output logic             ms_strobe
);

  logic [TPM_W-1:0] count;
  logic             at_last;

  // The strobe is combinational so the consumer acts on the same edge the count wraps.
  assign at_last   = (count == tpm - TPM_W'(1));
  assign ms_strobe = enable && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      // NOTE: non-blocking assignment for all clocked state so every register samples pre-edge values.
      count <= '0;
    end else if (enable) begin
      if (at_last) count <= '0;
      else         count <= count + TPM_W'(1);
    end
  end

endmodule

// File: rtl/note_player.sv
// Square-wave tone generator: plays one commanded note for a number of milliseconds,
// then holds a silent articulation gap before accepting the next note.
module note_player import note_player_pkg::*; #(
  parameter int HALF_W = HALF_W_DEFAULT,
  parameter int DUR_W  = DUR_W_DEFAULT,
  parameter int TPM_W  = TPM_W_DEFAULT,
  parameter int GAP_MS = GAP_MS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TPM_W-1:0] ticks_per_milli,
  note_if.slave            note,
  output logic             sound,
  output logic             playing,
  output logic             busy,
  output logic             note_done
);

  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

  state_e            state;
  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] phase;
  logic [DUR_W-1:0]  dur_q;
  logic [DUR_W-1:0]  ms_cnt;
  logic [TPM_W-1:0]  tpm_q;

  logic accept;
  logic ms_strobe;
  logic tone_last;
  logic gap_last;

  assign note.note_ready = (state == ST_IDLE);
  assign accept          = note.note_valid && note.note_ready;

  assign tone_last = ms_strobe && (ms_cnt == dur_q - DUR_W'(1));
  assign gap_last  = ms_strobe && (ms_cnt == GAP_LAST);

  ms_timer #(
    .TPM_W (TPM_W)
  ) u_ms_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .enable    (state != ST_IDLE),
    .tpm       (tpm_q),
    .ms_strobe (ms_strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      half_q    <= '0;
      dur_q     <= '0;
      tpm_q     <= '0;
      phase     <= '0;
      ms_cnt    <= '0;
      sound     <= 1'b0;
      playing   <= 1'b0;
      busy      <= 1'b0;
      note_done <= 1'b0;
    end else begin
      note_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            half_q <= note.note_half_period;
            dur_q  <= note.note_dur_ms;
            // A zero tick rate would stall the prescaler forever; treat it as one tick per ms.
            tpm_q  <= (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
            phase  <= '0;
            ms_cnt <= '0;
            sound  <= 1'b0;
            if (note.note_dur_ms == '0) begin
              note_done <= 1'b1;
            end else begin
              state   <= ST_TONE;
              busy    <= 1'b1;
              playing <= (note.note_half_period != '0);
            end
          end
        end

        ST_TONE: begin
          if (tone_last) begin
            sound   <= 1'b0;
            playing <= 1'b0;
            phase   <= '0;
            ms_cnt  <= '0;
            if (GAP_MS == 0) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              note_done <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            if (ms_strobe) ms_cnt <= ms_cnt + DUR_W'(1);
            // A zero half-period is a rest: timing runs but the pin stays low.
            if (half_q != '0) begin
              if (phase == half_q - HALF_W'(1)) begin
                sound <= ~sound;
                phase <= '0;
              end else begin
                phase <= phase + HALF_W'(1);
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_last) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            ms_cnt    <= '0;
            note_done <= 1'b1;
          end else if (ms_strobe) begin
            ms_cnt <= ms_cnt + DUR_W'(1);
          end
        end

        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          playing <= 1'b0;
          sound   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Tone-generation stage directly downstream of the note sequencer; drives the speaker pin.
- Accepts one note command at a time over a valid/ready handshake.
- Plays each note as a square wave at the commanded half-period for the commanded number of milliseconds, then inserts a fixed silent articulation gap.
- Milliseconds are timed from the board-level ticks_per_milli value.

Parameters:
- HALF_W, 16, width of note_half_period (clock cycles per half tone cycle)
- DUR_W, 12, width of note_dur_ms
- TPM_W, 16, width of ticks_per_milli
- GAP_MS, 10, silent gap after each note in ms; 0 = no gap

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ticks_per_milli  in  TPM_W  clock cycles per millisecond; sampled at note acceptance
- note_valid  in  1  upstream presents a note
- note_ready  out  1  block can accept a note
- note_half_period  in  HALF_W  tone half-period in clk cycles; 0 = rest (silence)
- note_dur_ms  in  DUR_W  note length in ms
- sound  out  1  square-wave speaker drive
- playing  out  1  high while in TONE with a nonzero half-period (LED indication)
- busy  out  1  high in TONE or GAP
- note_done  out  1  one-cycle pulse when a note (including its gap) completes

Behaviour:
- Reset (async, any time, including mid-note): state=IDLE; all counters cleared; latched note cleared.
  - sound=0, playing=0, busy=0, note_done=0, note_ready=1 immediately.
- States: IDLE, TONE, GAP. All outputs are registered, except note_ready, which equals (state==IDLE).
- IDLE: a handshake is note_valid && note_ready at a rising edge. On a handshake:
  - Latch half, dur, and tpm. Latched tpm = max(ticks_per_milli, 1).
  - Clear the prescaler, ms counter and phase counter. sound=0.
  - If dur==0: stay IDLE; note_done=1 for the next cycle; no sound.
  - Otherwise go to TONE.
- ms prescaler: counts 0..tpm-1 in TONE and GAP. At tpm-1 it wraps to 0 and emits an ms strobe.
- TONE lasts exactly dur*tpm cycles.
  - The ms counter counts strobes. On the dur-th strobe: sound=0, phase cleared, go to GAP (or to IDLE with note_done if GAP_MS==0).
- Tone phase (TONE only, half!=0): the phase counter increments each cycle.
  - When it equals half-1, sound toggles and the counter resets.
  - First rising edge of sound occurs `half` cycles after acceptance. Period = 2*half cycles.
  - half==1 toggles every cycle.
- Rest (half==0): sound and playing stay 0 for the full duration; timing is identical to a tone.
- GAP lasts exactly GAP_MS*tpm cycles with sound=0. On the final strobe: go IDLE and pulse note_done=1 for one cycle.
- Back-to-back: note_ready rises in the same cycle note_done pulses. A note presented that cycle is accepted without a dead cycle.
- ticks_per_milli and the note_* inputs are ignored outside the accepting cycle.
- Counter widths: prescaler TPM_W, ms counter DUR_W, phase HALF_W. No overflow is possible by construction.
- Total latency from accept edge to note_done high: dur*tpm + GAP_MS*tpm cycles. The dur==0 case takes 1 cycle.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE, ST_TONE, ST_GAP
  - default widths HALF_W, DUR_W, TPM_W
  - the GAP_MS default
- One sub-module, ms_timer: a prescaler taking clk, rst, clear, enable and tpm, producing a one-cycle ms_strobe.
  - Reused by the sequencer for tempo.
- The FSM and tone-phase counter remain in note_player.

Test Plan:
1. GAP_MS=2, tpm=4, half=2, dur=3, accept at edge N.
   - sound toggles at N+2, N+4, ... (3 full periods in 12 TONE cycles).
   - sound=0 through GAP; note_done high for one cycle at N+20; note_ready=1 from then.
2. Rest: half=0, dur=2, tpm=4, GAP_MS=2.
   - sound and playing stay 0 throughout; busy high for 16 cycles; note_done at accept+16.
3. dur=0 with half=5.
   - note_done pulses one cycle after accept; busy and sound never rise; the next note is accepted immediately.
4. ticks_per_milli=0, dur=5, half=1, GAP_MS=0.
   - tpm clamps to 1; TONE lasts 5 cycles; sound toggles every cycle; note_done at accept+5.
5. note_valid held high with two queued notes.
   - The second note is accepted in the same cycle note_done pulses for the first.
   - No extra idle cycle; a ticks_per_milli change between the notes affects only the second.
6. Assert rst mid-TONE while sound=1.
   - sound=0, busy=0 and note_ready=1 asynchronously, before the next clk edge.
   - After release, a new note plays with correct timing.
